// File: rtl/capture_sequencer.sv
// capture_sequencer: armed/triggered/done run control for the channel-A ADC capture path.
// Define CAPTURE_SEQ_FORCE_TRIG_EN to add the i_force_trig input.
module capture_sequencer #(
    parameter int unsigned DW       = 14,
    parameter int unsigned SETTLE_W = 16,
    parameter int unsigned LEN_W    = 12
) (
    input  logic             i_fco,
    input  logic             i_rst,
    input  logic             i_arm,
    input  logic             i_abort,
    input  logic             i_dco_locked,
    input  logic             i_fco_locked,
    input  logic [DW-1:0]    i_thresh,
    input  logic [LEN_W-1:0] i_post_len,
    input  logic [DW-1:0]    i_din,
    input  logic             i_din_vld,
    input  logic             i_fifo_full,
`ifdef CAPTURE_SEQ_FORCE_TRIG_EN
    input  logic             i_force_trig,
`endif
    output logic [DW-1:0]    o_dout,
    output logic             o_load,
    output logic             o_busy,
    output logic             o_trig,
    output logic             o_done,
    output logic             o_overflow,
    output logic             o_lock_err,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSettle   = 3'd1,
        StWaitTrig = 3'd2,
        StRecord   = 3'd3,
        StDone     = 3'd4
    } state_e;

    localparam logic [DW-1:0] Mid = {1'b1, {(DW-1){1'b0}}};

    state_e              r_state;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [LEN_W:0]      r_smp_cnt;
    logic [DW-1:0]       r_dout;
    logic                r_load;
    logic                r_busy;
    logic                r_trig;
    logic                r_done;
    logic                r_overflow;
    logic                r_lock_err;

    logic                w_locked;
    logic [DW-1:0]       w_mag;
    logic [LEN_W:0]      w_target;
    logic [LEN_W:0]      w_cnt_base;
    logic [LEN_W:0]      w_cnt_inc;
    logic [SETTLE_W-1:0] w_settle_nxt;
    logic                w_force_hit;
    logic                w_trig_cond;

`ifdef CAPTURE_SEQ_FORCE_TRIG_EN
    logic                r_force_pend;
    assign w_force_hit = i_force_trig | r_force_pend;
`else
    assign w_force_hit = 1'b0;
`endif

    assign w_locked     = i_dco_locked & i_fco_locked;
    // Offset-binary magnitude about mid-scale.
    assign w_mag        = (i_din >= Mid) ? (i_din - Mid) : (Mid - i_din);
    assign w_trig_cond  = (w_mag >= i_thresh) | w_force_hit;
    assign w_target     = (i_post_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, i_post_len};
    // The triggering sample is counted from zero, so it may also complete the record.
    assign w_cnt_base   = (r_state == StRecord) ? r_smp_cnt : '0;
    assign w_cnt_inc    = w_cnt_base + 1'b1;
    assign w_settle_nxt = r_settle_cnt + 1'b1;

    always_ff @(posedge i_fco) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_settle_cnt <= '0;
            r_smp_cnt    <= '0;
            r_dout       <= '0;
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
            r_trig       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_lock_err   <= 1'b0;
`ifdef CAPTURE_SEQ_FORCE_TRIG_EN
            r_force_pend <= 1'b0;
`endif
        end else begin
            r_dout <= i_din;
            r_load <= 1'b0;
            r_trig <= 1'b0;
`ifdef CAPTURE_SEQ_FORCE_TRIG_EN
            r_force_pend <= 1'b0;
`endif
            if (i_abort) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else if (r_busy && !w_locked) begin
                r_state    <= StIdle;
                r_busy     <= 1'b0;
                r_lock_err <= 1'b1;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_arm && w_locked) begin
                            r_state      <= StSettle;
                            r_busy       <= 1'b1;
                            r_settle_cnt <= '0;
                            r_overflow   <= 1'b0;
                            r_lock_err   <= 1'b0;
                        end
                    end
                    StSettle: begin
                        r_settle_cnt <= w_settle_nxt;
                        if (&w_settle_nxt) r_state <= StWaitTrig;
                    end
                    StWaitTrig, StRecord: begin
                        if (i_din_vld && (r_state == StRecord || w_trig_cond)) begin
                            if (r_state == StWaitTrig) r_trig <= 1'b1;
                            r_state <= StRecord;
                            if (i_fifo_full) begin
                                r_overflow <= 1'b1;
                                r_smp_cnt  <= w_cnt_base;
                            end else begin
                                r_load    <= 1'b1;
                                r_smp_cnt <= w_cnt_inc;
                                if (w_cnt_inc >= w_target) begin
                                    r_state <= StDone;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            end
                        end
`ifdef CAPTURE_SEQ_FORCE_TRIG_EN
                        else if (r_state == StWaitTrig) begin
                            r_force_pend <= r_force_pend | i_force_trig;
                        end
`endif
                    end
                    StDone: begin
                        if (i_arm) begin
                            r_done     <= 1'b0;
                            r_overflow <= 1'b0;
                            r_lock_err <= 1'b0;
                            if (w_locked) begin
                                r_state <= StWaitTrig;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= StIdle;
                            end
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_dout     = r_dout;
    assign o_load     = r_load;
    assign o_busy     = r_busy;
    assign o_trig     = r_trig;
    assign o_done     = r_done;
    assign o_overflow = r_overflow;
    assign o_lock_err = r_lock_err;
    assign o_state    = r_state;

endmodule

// File: tb/tb_capture_sequencer.sv
// Testbench for capture_sequencer: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the run-control rules.
`timescale 1ns/1ps
module tb_capture_sequencer;

    localparam int DW  = 14;
    localparam int SW  = 4;
    localparam int LW  = 4;
    localparam int MID = 1 << (DW - 1);
`ifdef CAPTURE_SEQ_FORCE_TRIG_EN
    localparam bit FORCE_EN = 1'b1;
`else
    localparam bit FORCE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, arm, abort, dco_locked, fco_locked, din_vld, fifo_full, force_trig;
    logic [DW-1:0] thresh, din;
    logic [LW-1:0] post_len;
    logic [DW-1:0] dout;
    logic          load, busy, trig, done, overflow, lock_err;
    logic [2:0]    state;

    always #5 clk = ~clk;

    capture_sequencer #(.DW(DW), .SETTLE_W(SW), .LEN_W(LW)) dut (
        .i_fco        (clk),
        .i_rst        (rst),
        .i_arm        (arm),
        .i_abort      (abort),
        .i_dco_locked (dco_locked),
        .i_fco_locked (fco_locked),
        .i_thresh     (thresh),
        .i_post_len   (post_len),
        .i_din        (din),
        .i_din_vld    (din_vld),
        .i_fifo_full  (fifo_full),
`ifdef CAPTURE_SEQ_FORCE_TRIG_EN
        .i_force_trig (force_trig),
`endif
        .o_dout       (dout),
        .o_load       (load),
        .o_busy       (busy),
        .o_trig       (trig),
        .o_done       (done),
        .o_overflow   (overflow),
        .o_lock_err   (lock_err),
        .o_state      (state)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_loads = 0;
    int first_dout = -1;

    // Reference model state: 0 idle, 1 settle, 2 wait, 3 record, 4 done.
    int m_state = 0, m_settle = 0, m_cnt = 0, m_dout = 0;
    bit m_load = 0, m_trig = 0, m_ovf = 0, m_lerr = 0, m_pend = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic take(input int tgt);
        if (fifo_full) m_ovf = 1'b1;
        else begin
            m_load = 1'b1;
            m_cnt++;
            if (m_cnt >= tgt) m_state = 4;
        end
    endtask

    task automatic model_step();
        int mag, tgt;
        bit locks, hit;
        locks  = dco_locked && fco_locked;
        mag    = (int'(din) >= MID) ? int'(din) - MID : MID - int'(din);
        tgt    = (post_len == 0) ? (1 << LW) : int'(post_len);
        m_load = 1'b0;
        m_trig = 1'b0;
        if (rst) begin
            m_state = 0; m_settle = 0; m_cnt = 0; m_dout = 0;
            m_ovf = 0; m_lerr = 0; m_pend = 0;
            return;
        end
        m_dout = int'(din);
        hit = (mag >= int'(thresh)) || (FORCE_EN && (force_trig || m_pend));
        if (abort) begin
            m_state = 0; m_pend = 0;
        end else if (m_state inside {1, 2, 3} && !locks) begin
            m_state = 0; m_lerr = 1; m_pend = 0;
        end else begin
            case (m_state)
                0: if (arm && locks) begin
                    m_state = 1; m_settle = 0; m_ovf = 0; m_lerr = 0;
                end
                1: begin
                    m_settle++;
                    if (m_settle == (1 << SW) - 1) m_state = 2;
                end
                2: if (din_vld && hit) begin
                    m_trig = 1; m_cnt = 0; m_pend = 0; m_state = 3;
                    take(tgt);
                end else begin
                    m_pend = FORCE_EN && (m_pend || force_trig);
                end
                3: if (din_vld) take(tgt);
                4: if (arm) begin
                    m_ovf = 0; m_lerr = 0;
                    m_state = locks ? 2 : 0;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        check("state", state, m_state);
        check("load", load, m_load);
        check("dout", dout, m_dout);
        check("busy", busy, m_state inside {1, 2, 3});
        check("done", done, m_state == 4);
        check("trig", trig, m_trig);
        check("overflow", overflow, m_ovf);
        check("lock_err", lock_err, m_lerr);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (load === 1'b1) begin
            if (n_loads == 0) first_dout = int'(dout);
            n_loads++;
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string tag);
        int i = 0;
        while (state !== 3'(s) && i < budget) begin
            tick();
            i++;
        end
        check(tag, state, s);
    endtask

    task automatic arm_and_settle();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        wait_state(2, 40, "settle_to_wait");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cycles;
        rst = 1; arm = 0; abort = 0; dco_locked = 0; fco_locked = 0;
        din_vld = 0; fifo_full = 0; force_trig = 0;
        thresh = 14'd100; din = 14'd8192; post_len = 4'd5;
        tick();
        tick();
        rst = 0;
        tick();
        check("rst_state", state, 0);
        check("rst_busy", busy, 0);

        // Arm without locks stays idle; with locks settles for 15 cycles.
        arm = 1;
        tick();
        check("arm_nolock", state, 0);
        dco_locked = 1; fco_locked = 1;
        tick();
        arm = 0;
        cycles = 0;
        while (state === 3'd1 && cycles < 40) begin
            tick();
            cycles++;
        end
        check("settle_len", cycles, 15);
        check("settle_end", state, 2);

        // Threshold trigger and 5-sample record.
        thresh = 100; post_len = 5; din_vld = 1; n_loads = 0; first_dout = -1;
        for (int i = 0; i < 10; i++) begin
            din = 14'd8192;
            tick();
        end
        check("no_early_trig", n_loads, 0);
        din = 14'd8300;
        tick();
        check("trig_pulse", trig, 1);
        check("first_dout", first_dout, 8300);
        din = 14'd8000;
        wait_state(4, 20, "rec_done");
        check("n_loads5", n_loads, 5);
        din_vld = 0;
        repeat (3) tick();
        check("done_held", done, 1);
        check("no_load_done", load, 0);

        // Overflow: 2nd and 3rd recorded samples dropped.
        arm = 1;
        tick();
        arm = 0;
        check("rearm_wait", state, 2);
        post_len = 4; n_loads = 0; din_vld = 1; din = 14'd8300;
        tick();
        din = 14'd8000; fifo_full = 1;
        tick();
        tick();
        fifo_full = 0;
        tick();
        tick();
        tick();
        check("ovf_loads", n_loads, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_done", state, 4);
        din_vld = 0;

        // Lock loss mid-record.
        arm = 1;
        tick();
        arm = 0;
        check("ovf_clr", overflow, 0);
        post_len = 0; din_vld = 1; din = 14'd8300;
        repeat (3) tick();
        fco_locked = 0;
        tick();
        check("ll_state", state, 0);
        check("ll_err", lock_err, 1);
        check("ll_done", done, 0);
        n_loads = 0;
        repeat (3) tick();
        check("ll_noload", n_loads, 0);
        fco_locked = 1; din_vld = 0;

        // Abort beats a crossing sample.
        arm_and_settle();
        check("lerr_clr", lock_err, 0);
        din = 14'd8300; din_vld = 1; abort = 1;
        tick();
        check("abort_state", state, 0);
        check("abort_trig", trig, 0);
        check("abort_load", load, 0);
        abort = 0; din_vld = 0;
        tick();

        // post_len = 0 records 2^LEN_W samples.
        arm_and_settle();
        post_len = 0; n_loads = 0; din = 14'd8300; din_vld = 1;
        wait_state(4, 40, "len0_done");
        check("len0_loads", n_loads, 16);
        din_vld = 0;

        // Force trigger against an unreachable threshold.
        arm = 1;
        tick();
        arm = 0;
        thresh = 14'd16383; force_trig = 1;
        tick();
        force_trig = 0; din = 14'd8192; din_vld = 1;
        tick();
        check("force_trig", trig, FORCE_EN);
        din_vld = 0; abort = 1;
        tick();
        abort = 0;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            abort      = ($urandom_range(0, 63) == 0);
            arm        = ($urandom_range(0, 7) == 0);
            dco_locked = ($urandom_range(0, 59) != 0);
            fco_locked = ($urandom_range(0, 59) != 0);
            din_vld    = ($urandom_range(0, 1) == 1);
            fifo_full  = ($urandom_range(0, 5) == 0);
            force_trig = ($urandom_range(0, 19) == 0);
            din        = DW'($urandom_range(0, (1 << DW) - 1));
            if ($urandom_range(0, 3) == 0) thresh = DW'($urandom_range(0, 9000));
            if ($urandom_range(0, 15) == 0) post_len = LW'($urandom_range(0, (1 << LW) - 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Run-control sequencer for the octal ADC capture path, clocked in the frame-clock (fco) domain after deserialisation.
- Waits for both DCMs to lock, then applies a settle interval.
- Watches channel A for an acoustic ping whose magnitude crosses a programmable threshold.
- Gates a fixed-length record of samples into the downstream FIFO via load, then holds done until the host re-arms.
- Replaces the free-running gate/load logic with a proper armed/triggered/done handshake.

Parameters:
DW, 14, ADC sample width (offset binary)
SETTLE_W, 16, settle counter width; settle lasts 2^SETTLE_W-1 cycles
LEN_W, 12, record length counter width

Ports:
fco  in  1  frame clock; all logic on posedge
rst  in  1  synchronous active-high reset
arm  in  1  host arm request, level-sampled per cycle
abort  in  1  host abort, highest priority after rst
dco_locked  in  1  bit-clock DCM lock
fco_locked  in  1  frame-clock DCM lock
thresh  in  DW  trigger magnitude threshold, sampled every cycle
post_len  in  LEN_W  samples per record; 0 means 2^LEN_W
din  in  DW  channel A sample
din_vld  in  1  din valid this cycle
fifo_full  in  1  downstream FIFO full
dout  out  DW  registered copy of din
load  out  1  FIFO write strobe for dout
busy  out  1  high in SETTLE, WAIT_TRIG, RECORD
trig  out  1  one-cycle pulse on trigger
done  out  1  record complete, held until arm or abort
overflow  out  1  sticky: sample dropped on fifo_full
lock_err  out  1  sticky: lock lost while busy
state  out  3  current state encoding, for debug

Behaviour:
Reset:
- All outputs 0, state=IDLE, counters 0.
- Sticky flags clear only on rst or on the cycle leaving IDLE/DONE via arm.

States, encoded IDLE=0, SETTLE=1, WAIT_TRIG=2, RECORD=3, DONE=4:
- IDLE: arm & dco_locked & fco_locked -> SETTLE; settle counter cleared. arm without both locks -> stay IDLE.
- SETTLE: counter increments each cycle. When all-ones -> WAIT_TRIG, so the settle interval is 2^SETTLE_W-1 cycles.
- WAIT_TRIG: on din_vld, compute mag = (din >= 2^(DW-1)) ? din-2^(DW-1) : 2^(DW-1)-din, DW bits unsigned. If mag >= thresh -> RECORD, with trig=1 in the following cycle. The triggering sample is the first one recorded.
- RECORD: each din_vld sample is either written or dropped.
  - Written: load=1 one cycle after din_vld, dout=that din, sample counter increments.
  - Dropped: if fifo_full is high on the din_vld cycle, the sample is not written, not counted, and overflow is set.
  - When the count reaches post_len (0 means 2^LEN_W) -> DONE.
- DONE: done=1, load=0. arm -> WAIT_TRIG directly (no re-settle) if both locks are high, else -> IDLE.

Global rules:
- Latency: din -> dout/load is exactly 1 cycle. dout updates every cycle regardless of state; load=0 outside RECORD.
- Lock loss: either lock low in SETTLE, WAIT_TRIG or RECORD -> IDLE next cycle, lock_err=1, record discarded (done stays 0).
- abort in any state -> IDLE next cycle. A load already registered for that cycle still issues.
- Simultaneous events, priority order: rst > abort > lock loss > trigger/count > arm.
- Trigger and final write in the same cycle: with post_len=1, the trigger sample completes the record. Next state DONE, trig and load both 1 in the same cycle.
- thresh=0: the first valid sample triggers.
- Sample counter: LEN_W+1 bits so 2^LEN_W is reachable with no wrap.

Optional Feature:
Macro CAPTURE_SEQ_FORCE_TRIG_EN.
- Defined: adds input force_trig (1 bit). In WAIT_TRIG, force_trig=1 triggers on the next din_vld sample regardless of mag/thresh; trig pulses as for a normal trigger. Ignored in all other states.
- Undefined: port absent; only the threshold comparison triggers.

Test Plan:
- Bench uses SETTLE_W=4 and LEN_W=4.
- Settle: locks=1, arm pulse -> SETTLE for 15 cycles, then state=2. busy=1 from the cycle after arm.
- Trigger and record: thresh=100, din=8192 for 10 samples, then 8300, then 8000 ... with post_len=5.
  - trig one cycle after the 8300 sample.
  - Exactly 5 load pulses; first dout=8300.
  - done=1; load=0 afterward.
- Overflow: fifo_full=1 on the 2nd and 3rd recorded samples with post_len=4 -> 4 loads total over 6 valid samples, overflow=1.
- Lock loss mid-record: fco_locked=0 during RECORD -> state=0 next cycle, lock_err=1, done=0, no further loads.
- Priority and re-arm:
  - abort and trigger-crossing sample in the same cycle -> IDLE, trig=0, load=0.
  - arm from DONE -> WAIT_TRIG without settle, overflow/lock_err cleared.
  - post_len=0 -> 16 loads.
- Force trigger (macro defined): thresh=16383, force_trig=1 in WAIT_TRIG -> trig on the next valid sample. With the macro undefined, the same stimulus gives no trigger.
